// File: rtl/fifo_reader_pkg.sv
// Shared constants, types and helpers for the fifo_reader read-side controller.
package fifo_reader_pkg;

  localparam int unsigned BITS_DEF   = 4;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned OCC_W      = 2;

  typedef logic [OCC_W-1:0] occ_t;

  // Skid buffer operation for one edge, encoded as {push, take}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_TAKE = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } skid_op_e;

  // True when one more pop still fits once the words already owed to the buffer land.
  function automatic logic has_credit(occ_t occ, logic inflight, logic xfer);
    logic [OCC_W:0] pend;
    pend = (OCC_W+1)'(occ) + (OCC_W+1)'(inflight) - (OCC_W+1)'(xfer);
    return pend < (OCC_W+1)'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// Valid/ready output stream of fifo_reader.
interface fifo_reader_if #(
  parameter int unsigned BITS = fifo_reader_pkg::BITS_DEF
) ();

  logic [BITS-1:0] dout;
  logic            dout_valid;
  logic            dout_ready;

  modport master (output dout, output dout_valid, input dout_ready);
  modport slave  (input dout, input dout_valid, output dout_ready);

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; entry0 is the head presented on dout.
module fifo_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            take,
  input  logic [BITS-1:0] din,
  output logic [BITS-1:0] dout,
  output logic            valid,
  output occ_t            occ
);

  logic [BITS-1:0] e0;
  logic [BITS-1:0] e1;
  skid_op_e        op;

  assign op = skid_op_e'({push, take});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e0  <= '0;
      e1  <= '0;
      occ <= '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          if (occ == occ_t'(0)) e0 <= din;
          else                  e1 <= din;
          occ <= occ + occ_t'(1);
        end
        OP_TAKE: begin
          e0  <= e1;
          occ <= occ - occ_t'(1);
        end
        // Occupancy unchanged; a lone head is replaced directly by the new word.
        OP_BOTH: begin
          if (occ == occ_t'(1)) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = e0;
  assign valid = (occ != occ_t'(0));

endmodule

// File: rtl/fifo_reader.sv
// Read-side FIFO controller: credit-based pop, latency absorption and delivered-word count.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned BITS  = BITS_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pndng,
  input  logic [BITS-1:0]  fifo_dout,
  output logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             idle,
  fifo_reader_if.master    out
);

  logic inflight;
  logic xfer;
  occ_t occ;

  assign xfer = out.dout_valid & out.dout_ready;

  // Gated by rst so no pop leaks to the FIFO while it is itself being cleared.
  assign pop  = rst & enable & pndng & has_credit(occ, inflight, xfer);

  assign idle = (occ == occ_t'(0)) & ~inflight & ~pndng;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      count    <= '0;
    end else begin
      inflight <= pop;
      if (xfer) count <= count + CNT_W'(1);
    end
  end

  fifo_skid_buf #(.BITS(BITS)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .take  (xfer),
    .din   (fifo_dout),
    .dout  (out.dout),
    .valid (out.dout_valid),
    .occ   (occ)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader driving a behavioural FIFO with one-cycle read latency.
module tb_fifo_reader;
  import fifo_reader_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       ovr_en;
  logic       ovr_val;
  logic       pndng;
  logic       pop;
  logic       idle;
  logic [3:0] fifo_dout = 4'h0;
  logic [7:0] count;

  logic [3:0] mem [0:1023];
  logic [3:0] rx  [0:1023];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int rx_n   = 0;
  int n_chk  = 0;
  int n_err  = 0;
  int base;
  int wbase;

  always #5 clk = ~clk;

  fifo_reader_if #(.BITS(4)) s ();

  fifo_reader #(.BITS(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pndng     (pndng),
    .fifo_dout (fifo_dout),
    .pop       (pop),
    .count     (count),
    .idle      (idle),
    .out       (s)
  );

  assign pndng = ovr_en ? ovr_val : (wr_cnt != rd_cnt);

  // FIFO model: registered read data one cycle after pop.
  always @(posedge clk) begin
    if (pop) begin
      fifo_dout <= mem[rd_cnt[9:0]];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // Log of every word the sink accepted.
  always @(posedge clk) begin
    if (rst && s.dout_valid && s.dout_ready) begin
      rx[rx_n[9:0]] <= s.dout;
      rx_n          <= rx_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    mem[wr_cnt[9:0]] = v;
    wr_cnt++;
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && rx_n < target; i++) tick();
    chk(tag, 32'(rx_n), 32'(target));
  endtask

  initial begin
    // Reset with pending data forced high
    rst = 1'b0; enable = 1'b1; ovr_en = 1'b1; ovr_val = 1'b1; s.dout_ready = 1'b1;
    repeat (3) tick();
    chk("rst_pop",   32'(pop), 0);
    chk("rst_valid", 32'(s.dout_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout",  32'(s.dout), 0);
    rst = 1'b1; #1;
    chk("release_pop", 32'(pop), 1);
    rst = 1'b0; #1;
    chk("reassert_pop", 32'(pop), 0);
    ovr_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("idle_after_rst", 32'(idle), 1);

    // Single word: valid exactly one cycle, two cycles after pop
    push(4'hA); #1;
    chk("single_pop", 32'(pop), 1);
    tick();
    chk("single_pop_c1", 32'(pop), 0);
    chk("single_valid_c1", 32'(s.dout_valid), 0);
    tick();
    chk("single_valid_c2", 32'(s.dout_valid), 1);
    chk("single_dout", 32'(s.dout), 32'h0A);
    tick();
    chk("single_valid_c3", 32'(s.dout_valid), 0);
    chk("single_count", 32'(count), 1);

    // Streaming 1..4 with sink always ready
    push(4'h1); push(4'h2); push(4'h3); push(4'h4); #1;
    chk("stream_pop_c0", 32'(pop), 1);
    tick();
    chk("stream_pop_c1", 32'(pop), 1);
    chk("stream_valid_c1", 32'(s.dout_valid), 0);
    tick();
    chk("stream_pop_c2", 32'(pop), 1);
    chk("stream_dout_c2", 32'(s.dout), 1);
    tick();
    chk("stream_pop_c3", 32'(pop), 1);
    chk("stream_dout_c3", 32'(s.dout), 2);
    chk("stream_occ_c3", 32'(dut.u_skid.occ), 1);
    tick();
    chk("stream_pop_c4", 32'(pop), 0);
    chk("stream_dout_c4", 32'(s.dout), 3);
    chk("stream_occ_c4", 32'(dut.u_skid.occ), 1);
    tick();
    chk("stream_dout_c5", 32'(s.dout), 4);
    chk("stream_valid_c5", 32'(s.dout_valid), 1);
    tick();
    chk("stream_valid_c6", 32'(s.dout_valid), 0);
    chk("stream_count", 32'(count), 5);

    // Backpressure: pops stop at two outstanding words, head held
    s.dout_ready = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4); #1;
    chk("bp_pop_c0", 32'(pop), 1);
    tick();
    chk("bp_pop_c1", 32'(pop), 1);
    tick();
    chk("bp_pop_c2", 32'(pop), 0);
    chk("bp_dout_c2", 32'(s.dout), 1);
    tick();
    chk("bp_pop_c3", 32'(pop), 0);
    chk("bp_occ_c3", 32'(dut.u_skid.occ), 2);
    tick();
    chk("bp_pop_c4", 32'(pop), 0);
    chk("bp_dout_c4", 32'(s.dout), 1);
    chk("bp_valid_c4", 32'(s.dout_valid), 1);
    s.dout_ready = 1'b1; #1;
    chk("bp_pop_ready", 32'(pop), 1);
    wait_rx("bp_drain", 9, 20);
    chk("bp_rx0", 32'(rx[5]), 1);
    chk("bp_rx1", 32'(rx[6]), 2);
    chk("bp_rx2", 32'(rx[7]), 3);
    chk("bp_rx3", 32'(rx[8]), 4);
    chk("bp_count", 32'(count), 9);
    tick();
    chk("bp_no_dup", 32'(s.dout_valid), 0);
    chk("bp_idle", 32'(idle), 1);

    // 200 random words with random sink stalls against the pushed sequence
    base = rx_n; wbase = wr_cnt;
    for (int i = 0; i < 200; i++) push(4'($urandom_range(0, 15)));
    for (int i = 0; i < 3000 && rx_n < base + 200; i++) begin
      s.dout_ready = 1'($urandom_range(0, 1));
      tick();
    end
    s.dout_ready = 1'b1;
    chk("rand_total", 32'(rx_n), 32'(base + 200));
    for (int i = 0; i < 200; i++)
      chk($sformatf("rand_word%0d", i), 32'(rx[base + i]), 32'(mem[wbase + i]));
    chk("rand_count", 32'(count), 209);
    tick();
    chk("rand_no_dup", 32'(s.dout_valid), 0);

    // Reset while the buffer is full
    s.dout_ready = 1'b0;
    push(4'h9); push(4'h6);
    repeat (3) tick();
    chk("mr_occ_full", 32'(dut.u_skid.occ), 2);
    chk("mr_dout_pre", 32'(s.dout), 9);
    rst = 1'b0; #1;
    chk("mr_valid", 32'(s.dout_valid), 0);
    chk("mr_dout", 32'(s.dout), 0);
    chk("mr_pop", 32'(pop), 0);
    chk("mr_count", 32'(count), 0);
    tick();
    rst = 1'b1; #1;

    // enable falls with a pop in flight: that word still arrives, no further pops
    base = rx_n;
    push(4'hC); push(4'hD); push(4'hE); #1;
    chk("en_pop_c0", 32'(pop), 1);
    tick();
    enable = 1'b0; #1;
    chk("en_pop_c1", 32'(pop), 0);
    tick();
    chk("en_dout_c2", 32'(s.dout), 32'h0C);
    chk("en_pop_c2", 32'(pop), 0);
    s.dout_ready = 1'b1;
    tick();
    chk("en_valid_c3", 32'(s.dout_valid), 0);
    chk("en_pop_c3", 32'(pop), 0);
    chk("en_idle_pending", 32'(idle), 0);
    chk("en_rx_n", 32'(rx_n), 32'(base + 1));
    chk("en_rx", 32'(rx[base]), 32'h0C);
    chk("en_count", 32'(count), 1);
    wr_cnt = rd_cnt; #1;
    chk("en_idle", 32'(idle), 1);
    enable = 1'b1;

    // Counter wrap 255 -> 0
    base = rx_n;
    for (int i = 0; i < 254; i++) push(4'(i));
    wait_rx("wrap_drain", base + 254, 600);
    chk("wrap_count_255", 32'(count), 255);
    push(4'h7);
    wait_rx("wrap_last", base + 255, 20);
    chk("wrap_count_0", 32'(count), 0);
    chk("wrap_rx", 32'(rx[base + 254]), 7);
    tick();
    chk("wrap_idle", 32'(idle), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
